// File: rtl/uart_pkg.sv
// Shared types and bit-timing helpers for the UART operand loader.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        STOP_WAIT
    } rx_state_e;

    typedef enum logic {
        WAIT_A,
        WAIT_B
    } seq_state_e;

    function automatic int calc_bit_ticks(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_half_ticks(input int bit_ticks);
        return bit_ticks / 2;
    endfunction

endpackage

// File: rtl/uart_operand_loader_if.sv
// Operand bus from the UART loader to the divider datapath.
interface uart_operand_loader_if #(
    parameter int p_N = 8
);
    logic [p_N-1:0] o_a;
    logic [p_N-1:0] o_b;
    logic           o_valid;
    logic           o_frame_err;
    logic           o_busy;

    modport master (output o_a, o_b, o_valid, o_frame_err, o_busy);
    modport slave  (input  o_a, o_b, o_valid, o_frame_err, o_busy);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, mid-bit sampling FSM, tick/bit counters.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 57600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       frame_err,
    output logic       busy
);
    localparam int BIT_TICKS  = calc_bit_ticks(clk_freq, uart_baud_rate);
    localparam int HALF_TICKS = calc_half_ticks(BIT_TICKS);
    localparam int CW         = $clog2(BIT_TICKS);
    localparam logic [CW-1:0] BIT_TC  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] HALF_TC = CW'(HALF_TICKS - 1);

    logic          rx_meta, rxs;
    rx_state_e     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shreg, shreg_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            shreg   <= shreg_d;
        end
    end

    // Every state transition clears the tick counter so each phase times from its own entry.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 1'b1;
        idx_d     = idx;
        shreg_d   = shreg;
        byte_done = 1'b0;
        frame_err = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt == HALF_TC) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_TC) begin
                    cnt_d        = '0;
                    shreg_d[idx] = rxs;
                    idx_d        = idx + 3'd1;
                    if (idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_TC) begin
                    cnt_d = '0;
                    if (rxs) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = STOP_WAIT;
                    end
                end
            end
            STOP_WAIT: begin
                // Hold off until the line recovers so a break is not read as new start bits.
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign rx_byte = shreg;
    assign busy    = (state != IDLE);
endmodule

// File: rtl/uart_operand_loader.sv
// Pairs received bytes into dividend/divisor registers for the divider, strobing o_valid per pair.
module uart_operand_loader
    import uart_pkg::*;
#(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 57600,
    parameter int p_N            = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rxd,
    uart_operand_loader_if.master dout
);
    logic [7:0]     rx_byte;
    logic           byte_done, frame_err, busy;

    seq_state_e     seq, seq_d;
    logic [p_N-1:0] a_hold, a_hold_d;
    logic [p_N-1:0] a_q, a_d, b_q, b_d;
    logic           valid_q, valid_d, ferr_q, ferr_d;

    uart_rx_byte #(
        .clk_freq      (clk_freq),
        .uart_baud_rate(uart_baud_rate)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (uart_rxd),
        .rx_byte  (rx_byte),
        .byte_done(byte_done),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seq     <= WAIT_A;
            a_hold  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            seq     <= seq_d;
            a_hold  <= a_hold_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // byte_done and frame_err are mutually exclusive, so the strobes can never coincide.
    always_comb begin
        seq_d    = seq;
        a_hold_d = a_hold;
        a_d      = a_q;
        b_d      = b_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        if (frame_err) begin
            ferr_d   = 1'b1;
            a_hold_d = '0;
            seq_d    = WAIT_A;
        end else if (byte_done) begin
            unique case (seq)
                WAIT_A: begin
                    a_hold_d = rx_byte[p_N-1:0];
                    seq_d    = WAIT_B;
                end
                WAIT_B: begin
                    a_d     = a_hold;
                    b_d     = rx_byte[p_N-1:0];
                    valid_d = 1'b1;
                    seq_d   = WAIT_A;
                end
                default: seq_d = WAIT_A;
            endcase
        end
    end

    assign dout.o_a         = a_q;
    assign dout.o_b         = b_q;
    assign dout.o_valid     = valid_q;
    assign dout.o_frame_err = ferr_q;
    assign dout.o_busy      = busy;
endmodule

// File: tb/tb_uart_operand_loader.sv
// Bench for uart_operand_loader: an 8-bit and a 4-bit instance share one serial line.
module tb_uart_operand_loader;
    localparam int CLK_HZ = 2000000;
    localparam int BAUD   = 57600;
    localparam int BT     = CLK_HZ / BAUD;
    localparam int HT     = BT / 2;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    always #5 clk = ~clk;

    uart_operand_loader_if #(.p_N(8)) if8 ();
    uart_operand_loader_if #(.p_N(4)) if4 ();

    uart_operand_loader #(.clk_freq(CLK_HZ), .uart_baud_rate(BAUD), .p_N(8)) dut8 (
        .clk(clk), .rst(rst), .uart_rxd(rxd), .dout(if8)
    );
    uart_operand_loader #(.clk_freq(CLK_HZ), .uart_baud_rate(BAUD), .p_N(4)) dut4 (
        .clk(clk), .rst(rst), .uart_rxd(rxd), .dout(if4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    typedef struct {
        logic [7:0] b0;
        bit         ok0;
        logic [7:0] b1;
        bit         ok1;
        int         n_valid;
        int         n_ferr;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [3:0] ea4;
        logic [3:0] eb4;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    int    busy_cnt = 0;
    int    valid_cnt = 0;
    int    ferr_cnt = 0;
    int    exp_ferr = 0;
    pair_t expq[$];
    bit    have_a = 0;
    logic [7:0] hold_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of time; also the scoreboard watching the output strobes.
    task automatic tick();
        pair_t p;
        @(negedge clk);
        if (if8.o_busy) busy_cnt++;
        if (if8.o_valid || if4.o_valid) begin
            valid_cnt++;
            chk("valid_both", 32'({if8.o_valid, if4.o_valid}), 32'd3);
            chk("valid_pending", 32'(expq.size() > 0), 32'd1);
            if (expq.size() > 0) begin
                p = expq.pop_front();
                chk("sb_a8", 32'(if8.o_a), 32'(p.a));
                chk("sb_b8", 32'(if8.o_b), 32'(p.b));
                chk("sb_a4", 32'(if4.o_a), 32'(p.a[3:0]));
                chk("sb_b4", 32'(if4.o_b), 32'(p.b[3:0]));
            end
        end
        if (if8.o_frame_err || if4.o_frame_err) begin
            ferr_cnt++;
            chk("ferr_both", 32'({if8.o_frame_err, if4.o_frame_err}), 32'd3);
            chk("ferr_excl", 32'(if8.o_valid), 32'd0);
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (BT) tick();
    endtask

    // Model: good bytes alternate dividend/divisor, a bad stop bit drops any held dividend.
    task automatic send_byte(input logic [7:0] d, input bit ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (ok) begin
            if (have_a) begin
                expq.push_back('{hold_a, d});
                have_a = 0;
            end else begin
                hold_a = d;
                have_a = 1;
            end
        end else begin
            have_a = 0;
            exp_ferr++;
        end
        drive_bit(ok ? 1'b1 : 1'b0);
        if (!ok) drive_bit(1'b1);
    endtask

    vec_t tbl[6];

    initial begin
        int v0, f0, b0;
        logic [7:0] rb;
        bit rok;

        tbl[0] = '{8'h2A, 1'b1, 8'h05, 1'b1, 1, 0, 8'h2A, 8'h05, 4'hA, 4'h5};
        tbl[1] = '{8'h11, 1'b1, 8'h22, 1'b0, 0, 1, 8'h2A, 8'h05, 4'hA, 4'h5};
        tbl[2] = '{8'h64, 1'b1, 8'h07, 1'b1, 1, 0, 8'h64, 8'h07, 4'h4, 4'h7};
        tbl[3] = '{8'h80, 1'b1, 8'h01, 1'b1, 1, 0, 8'h80, 8'h01, 4'h0, 4'h1};
        tbl[4] = '{8'hC8, 1'b1, 8'h0A, 1'b1, 1, 0, 8'hC8, 8'h0A, 4'h8, 4'hA};
        tbl[5] = '{8'hAB, 1'b1, 8'hCD, 1'b1, 1, 0, 8'hAB, 8'hCD, 4'hB, 4'hD};

        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) tick();
        chk("rst_a", 32'(if8.o_a), 32'd0);
        chk("rst_b", 32'(if8.o_b), 32'd0);
        chk("rst_valid", 32'(if8.o_valid), 32'd0);
        chk("rst_ferr", 32'(if8.o_frame_err), 32'd0);
        chk("rst_busy", 32'(if8.o_busy), 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        // Short low pulse: half-bit start qualification rejects it.
        b0 = busy_cnt; v0 = valid_cnt; f0 = ferr_cnt;
        rxd = 1'b0;
        repeat (10) tick();
        rxd = 1'b1;
        repeat (2 * BT) tick();
        chk("glitch_busy_cycles", 32'(busy_cnt - b0), 32'(HT));
        chk("glitch_busy_now", 32'(if8.o_busy), 32'd0);
        chk("glitch_valid", 32'(valid_cnt - v0), 32'd0);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        send_byte(8'h33, 1);
        send_byte(8'h44, 1);
        chk("post_glitch_a", 32'(if8.o_a), 32'h33);
        chk("post_glitch_b", 32'(if8.o_b), 32'h44);

        for (int r = 0; r < 6; r++) begin
            v0 = valid_cnt; f0 = ferr_cnt;
            send_byte(tbl[r].b0, tbl[r].ok0);
            send_byte(tbl[r].b1, tbl[r].ok1);
            chk($sformatf("row%0d_valid", r), 32'(valid_cnt - v0), 32'(tbl[r].n_valid));
            chk($sformatf("row%0d_ferr", r), 32'(ferr_cnt - f0), 32'(tbl[r].n_ferr));
            chk($sformatf("row%0d_a8", r), 32'(if8.o_a), 32'(tbl[r].ea));
            chk($sformatf("row%0d_b8", r), 32'(if8.o_b), 32'(tbl[r].eb));
            chk($sformatf("row%0d_a4", r), 32'(if4.o_a), 32'(tbl[r].ea4));
            chk($sformatf("row%0d_b4", r), 32'(if4.o_b), 32'(tbl[r].eb4));
        end

        // Reset in the middle of bit 4 while a dividend is already held.
        send_byte(8'h99, 1);
        v0 = valid_cnt; f0 = ferr_cnt;
        rb = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rb[i]);
        rxd = rb[4];
        repeat (HT) tick();
        rst = 1'b1;
        rxd = 1'b1;
        have_a = 0;
        repeat (3) tick();
        chk("midrst_a", 32'(if8.o_a), 32'd0);
        chk("midrst_b", 32'(if8.o_b), 32'd0);
        chk("midrst_busy", 32'(if8.o_busy), 32'd0);
        rst = 1'b0;
        repeat (2 * BT) tick();
        chk("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("midrst_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        send_byte(8'hFF, 1);
        send_byte(8'h0F, 1);
        chk("midrst_pair_a8", 32'(if8.o_a), 32'hFF);
        chk("midrst_pair_b8", 32'(if8.o_b), 32'h0F);
        chk("midrst_pair_a4", 32'(if4.o_a), 32'hF);
        chk("midrst_pair_b4", 32'(if4.o_b), 32'hF);

        for (int i = 0; i < 20; i++) begin
            rb  = 8'($urandom);
            rok = ($urandom_range(0, 9) != 0);
            send_byte(rb, rok);
        end
        repeat (2 * BT) tick();
        chk("final_pairs_left", 32'(expq.size()), 32'd0);
        chk("final_ferr_count", 32'(ferr_cnt), 32'(exp_ferr));
        chk("final_busy", 32'(if8.o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
